data_cache_controller: RTL and testbench
========================================

Name: data_cache_controller

Overview:
- Control stage directly upstream of the direct-mapped data cache storage array (8 sets, one 32-bit word per line, 27-bit tag).
- Accepts load/store requests from the memory stage and splits each address into tag, set and offset.
- Drives the array's set/write ports and compares the returned valid/tag on the following cycle.
- Services read misses and all writes (write-through, no-write-allocate) over a req/ack main-memory handshake, and keeps saturating hit/miss statistics.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
SET_WIDTH, 3, set index bits (2**SET_WIDTH lines)
TAG_WIDTH, 27, ADDRESS_WIDTH-SET_WIDTH-2
STAT_WIDTH, 16, hit/miss counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored
req_wdata  in  DATA_WIDTH  store data
req_ready  out  1  controller can accept a request
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  load data; 0 for stores
cache_set  out  SET_WIDTH  set index to array
cache_we  out  1  array write enable (fill or store-hit update)
cache_wtag  out  TAG_WIDTH  tag written with the line
cache_wdata  out  DATA_WIDTH  data written to the line
cache_v  in  1  array valid bit (registered, 1-cycle read)
cache_tag  in  TAG_WIDTH  array tag
cache_rd  in  DATA_WIDTH  array data
mem_req  out  1  main-memory request, held until ack
mem_we  out  1  memory write
mem_addr  out  ADDRESS_WIDTH  word-aligned address ([1:0]=0)
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory completion; mem_rdata valid this cycle
mem_rdata  in  DATA_WIDTH  memory read data
hit_count  out  STAT_WIDTH  saturating lookup-hit count
miss_count  out  STAT_WIDTH  saturating lookup-miss count

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all outputs are 0 except req_ready=1.
  - Latched request is cleared; counters are cleared.
  - An in-flight memory transaction is abandoned: mem_req drops immediately.
- Address split: tag=addr[31:5], set=addr[4:2]. req_addr, req_we and req_wdata are latched on acceptance.
- cache_set always shows the latched set, or req_addr[4:2] in IDLE.
- IDLE:
  - req_ready=1.
  - req_valid -> latch the request -> LOOKUP.
  - mem_ack in IDLE is ignored.
- LOOKUP:
  - req_ready=0.
  - hit = cache_v && (cache_tag == latched tag). hit_count or miss_count increments by 1 and saturates at all-ones.
  - Load hit: resp_valid=1, resp_rdata=cache_rd -> IDLE. Accept-to-response latency is 1 cycle.
  - Load miss -> MEM_RD.
  - Store hit: cache_we=1, cache_wtag=latched tag, cache_wdata=req_wdata -> MEM_WR.
  - Store miss -> MEM_WR with no array write.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr={tag,set,2'b00}. Outputs are held stable until mem_ack.
  - On mem_ack: cache_we=1 with the latched tag and mem_rdata (array sets valid), resp_valid=1, resp_rdata=mem_rdata -> IDLE.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_wdata=latched wdata, held until mem_ack.
  - On mem_ack: resp_valid=1, resp_rdata=0 -> IDLE.
- Back-to-back requests: a new request can be accepted in the cycle after resp_valid. There is no accept in the response cycle.
- mem_ack arriving in the same cycle as mem_req first rises is legal and completes that cycle.
- Same-set conflict: a fill overwrites the line unconditionally; the array is direct-mapped, so there is no replacement choice.
- req_valid while not ready is held by the requester; the controller does not sample it.

Decomposition:
- cache_pkg holds:
  - width localparams;
  - the state enum {IDLE, LOOKUP, MEM_RD, MEM_WR};
  - functions addr_tag(), addr_set() and word_addr().
- One sub-module, cache_stat_counter (enable, saturating, async-reset counter), instantiated twice for hit_count and miss_count.

Test Plan:
- Load miss: reset, load 0x0000_0104; memory acks after 3 cycles with 0xDEAD_BEEF -> mem_addr=0x104, fill set 1 tag 0x8, resp_rdata=0xDEAD_BEEF, miss_count=1.
- Load hit: repeat load 0x104 with the array returning v=1, tag=0x8, rd=0xDEAD_BEEF -> resp_valid 1 cycle after accept, no mem_req, hit_count=1.
- Conflict miss: load 0x0000_0124 (same set 1, tag 0x9) -> miss, fill with tag 0x9; a subsequent 0x104 misses again.
- Store: store 0x104 / 0x1234_5678 on a hit -> cache_we with the new data in LOOKUP, then mem_we=1 until ack, resp_rdata=0. A store miss issues no cache_we.
- Reset mid-MEM_RD: assert rst_n=0 while mem_req=1 -> mem_req=0 asynchronously, req_ready=1, counters 0; a late mem_ack is ignored.
- Saturation: STAT_WIDTH=4, 17 misses -> miss_count stays at 15.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, controller state encoding and address-split helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cache_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int SET_WIDTH     = 3;
  localparam int TAG_WIDTH     = ADDRESS_WIDTH - SET_WIDTH - 2;
  localparam int STAT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  // Upper address bits above the set index form the tag.
  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDRESS_WIDTH-1:0] a);
    return a[ADDRESS_WIDTH-1:SET_WIDTH+2];
  endfunction

  // Word index within the direct-mapped array.
  function automatic logic [SET_WIDTH-1:0] addr_set(input logic [ADDRESS_WIDTH-1:0] a);
    return a[SET_WIDTH+1:2];
  endfunction

  // Byte address with the in-word offset forced to zero.
  function automatic logic [ADDRESS_WIDTH-1:0] word_addr(input logic [ADDRESS_WIDTH-1:0] a);
    return {a[ADDRESS_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/data_cache_controller_if.sv
// Request/response, array and main-memory signal bundle for the cache controller.
// Latency: none (wiring only).
// Backpressure: req_valid held by master until req_ready; mem_req held until mem_ack.
interface data_cache_controller_if;

  logic                                  req_valid;
  logic                                  req_we;
  logic [cache_pkg::ADDRESS_WIDTH-1:0]   req_addr;
  logic [cache_pkg::DATA_WIDTH-1:0]      req_wdata;
  logic                                  req_ready;
  logic                                  resp_valid;
  logic [cache_pkg::DATA_WIDTH-1:0]      resp_rdata;

  logic [cache_pkg::SET_WIDTH-1:0]       cache_set;
  logic                                  cache_we;
  logic [cache_pkg::TAG_WIDTH-1:0]       cache_wtag;
  logic [cache_pkg::DATA_WIDTH-1:0]      cache_wdata;
  logic                                  cache_v;
  logic [cache_pkg::TAG_WIDTH-1:0]       cache_tag;
  logic [cache_pkg::DATA_WIDTH-1:0]      cache_rd;

  logic                                  mem_req;
  logic                                  mem_we;
  logic [cache_pkg::ADDRESS_WIDTH-1:0]   mem_addr;
  logic [cache_pkg::DATA_WIDTH-1:0]      mem_wdata;
  logic                                  mem_ack;
  logic [cache_pkg::DATA_WIDTH-1:0]      mem_rdata;

  // Environment side: requester, storage array and main memory.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  cache_set, cache_we, cache_wtag, cache_wdata,
    output cache_v, cache_tag, cache_rd,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output cache_set, cache_we, cache_wtag, cache_wdata,
    input  cache_v, cache_tag, cache_rd,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

endinterface

// File: rtl/cache_stat_counter.sv
// Saturating event counter: counts enable pulses, sticks at all-ones.
// Latency: count updates one cycle after en.
// Backpressure: none; en is sampled every cycle.
module cache_stat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Increment on enable unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through/no-write-allocate control stage in front of the data array.
// Latency: load hit responds 1 cycle after accept; misses and stores respond on mem_ack.
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack, no accept in response cycle.
module data_cache_controller
  import cache_pkg::*;
#(
  parameter int STAT_WIDTH = cache_pkg::STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_cache_controller_if.slave bus,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_we;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_ready;
  logic                     r_mem_req;
  logic                     r_mem_we;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;

  logic [TAG_WIDTH-1:0]     w_tag;
  logic [SET_WIDTH-1:0]     w_set;
  logic                     w_hit;
  logic                     w_inc_hit;
  logic                     w_inc_miss;
  logic                     w_resp_valid;
  logic [DATA_WIDTH-1:0]    w_resp_rdata;
  logic                     w_cache_we;
  logic [TAG_WIDTH-1:0]     w_cache_wtag;
  logic [DATA_WIDTH-1:0]    w_cache_wdata;

  assign w_tag = addr_tag(r_addr);
  assign w_set = addr_set(r_addr);
  // The array answers one cycle after it sees the set, i.e. during LOOKUP.
  assign w_hit = bus.cache_v && (bus.cache_tag == w_tag);

  // State sequencing; request latch and memory-side outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_ready     <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= word_addr(bus.req_addr);
            r_we    <= bus.req_we;
            r_wdata <= bus.req_wdata;
            r_ready <= 1'b0;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!r_we && w_hit) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            // Load miss fetches the word; every store is written through.
            r_mem_req   <= 1'b1;
            r_mem_we    <= r_we;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_we ? r_wdata : '0;
            r_state     <= r_we ? MEM_WR : MEM_RD;
          end
        end
        MEM_RD, MEM_WR: begin
          if (bus.mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Same-cycle outputs that depend on the array read or on mem_ack.
  always_comb begin
    w_inc_hit     = 1'b0;
    w_inc_miss    = 1'b0;
    w_resp_valid  = 1'b0;
    w_resp_rdata  = '0;
    w_cache_we    = 1'b0;
    w_cache_wtag  = '0;
    w_cache_wdata = '0;
    case (r_state)
      LOOKUP: begin
        w_inc_hit  = w_hit;
        w_inc_miss = !w_hit;
        if (w_hit && !r_we) begin
          w_resp_valid = 1'b1;
          w_resp_rdata = bus.cache_rd;
        end
        if (w_hit && r_we) begin
          w_cache_we    = 1'b1;
          w_cache_wtag  = w_tag;
          w_cache_wdata = r_wdata;
        end
      end
      MEM_RD: begin
        if (bus.mem_ack) begin
          // Fill replaces whatever the set held; direct-mapped, no choice.
          w_resp_valid  = 1'b1;
          w_resp_rdata  = bus.mem_rdata;
          w_cache_we    = 1'b1;
          w_cache_wtag  = w_tag;
          w_cache_wdata = bus.mem_rdata;
        end
      end
      MEM_WR: begin
        if (bus.mem_ack) begin
          w_resp_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready   = r_ready;
  assign bus.resp_valid  = w_resp_valid;
  assign bus.resp_rdata  = w_resp_rdata;
  assign bus.cache_set   = (r_state == IDLE) ? addr_set(bus.req_addr) : w_set;
  assign bus.cache_we    = w_cache_we;
  assign bus.cache_wtag  = w_cache_wtag;
  assign bus.cache_wdata = w_cache_wdata;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;

  cache_stat_counter #(.WIDTH(STAT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_inc_hit),
    .count (hit_count)
  );

  cache_stat_counter #(.WIDTH(STAT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_inc_miss),
    .count (miss_count)
  );

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller with a behavioural 8-line array model.
// Latency: checks 1-cycle load-hit response and mem_ack-timed completions.
// Backpressure: memory acks are driven by the tasks at chosen cycles.
module tb_data_cache_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] hit_count;
  logic [3:0] miss_count;
  int         checks;
  int         passed;

  data_cache_controller_if bus ();

  data_cache_controller #(.STAT_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array model: registered 1-cycle read, write on cache_we.
  logic [7:0]  arr_v;
  logic [26:0] arr_tag [8];
  logic [31:0] arr_dat [8];
  logic        arr_flush;

  always @(posedge clk) begin
    if (arr_flush) begin
      arr_v <= '0;
    end else if (bus.cache_we) begin
      arr_v[bus.cache_set]   <= 1'b1;
      arr_tag[bus.cache_set] <= bus.cache_wtag;
      arr_dat[bus.cache_set] <= bus.cache_wdata;
    end
    bus.cache_v   <= arr_v[bus.cache_set];
    bus.cache_tag <= arr_tag[bus.cache_set];
    bus.cache_rd  <= arr_dat[bus.cache_set];
  end

  // Present one request at a negedge; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    arr_flush = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%h exp=1", bus.req_ready); else passed++;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%h exp=0", bus.resp_valid); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got=%h exp=0", bus.mem_req); else passed++;
    checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); else passed++;
    checks++; if (bus.cache_we !== 1'b0) $display("FAIL reset_cache_we got=%h exp=0", bus.cache_we); else passed++;
    checks++; if ({hit_count, miss_count} !== 8'h00) $display("FAIL reset_counts got=%h exp=00", {hit_count, miss_count}); else passed++;
    rst_n     = 1'b1;
    arr_flush = 1'b0;
  endtask

  task automatic test_load_miss;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL miss_ready_idle got=%h exp=1", bus.req_ready); else passed++;
    issue(1'b0, 32'h0000_0104, 32'h0);
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL miss_lookup_resp got=%h exp=0", bus.resp_valid); else passed++;
    checks++; if (bus.req_ready !== 1'b0) $display("FAIL miss_lookup_ready got=%h exp=0", bus.req_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h0000_0104})
        $display("FAIL miss_mem_hold cyc=%0d got req=%h we=%h addr=%h exp req=1 we=0 addr=00000104", i, bus.mem_req, bus.mem_we, bus.mem_addr);
      else passed++;
    end
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.resp_valid !== 1'b1) $display("FAIL miss_resp_valid got=%h exp=1", bus.resp_valid); else passed++;
    checks++; if (bus.resp_rdata !== 32'hDEAD_BEEF) $display("FAIL miss_resp_rdata got=%h exp=deadbeef", bus.resp_rdata); else passed++;
    checks++;
    if ({bus.cache_we, bus.cache_set, bus.cache_wtag, bus.cache_wdata} !== {1'b1, 3'd1, 27'h8, 32'hDEAD_BEEF})
      $display("FAIL miss_fill got we=%h set=%h tag=%h data=%h exp we=1 set=1 tag=8 data=deadbeef", bus.cache_we, bus.cache_set, bus.cache_wtag, bus.cache_wdata);
    else passed++;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL miss_back_idle got=%h exp=1", bus.req_ready); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL miss_mem_req_drop got=%h exp=0", bus.mem_req); else passed++;
    checks++; if (miss_count !== 4'd1) $display("FAIL miss_count1 got=%0d exp=1", miss_count); else passed++;
  endtask

  task automatic test_load_hit;
    issue(1'b0, 32'h0000_0104, 32'h0);
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b1) $display("FAIL hit_resp_valid got=%h exp=1", bus.resp_valid); else passed++;
    checks++; if (bus.resp_rdata !== 32'hDEAD_BEEF) $display("FAIL hit_resp_rdata got=%h exp=deadbeef", bus.resp_rdata); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL hit_no_mem_req got=%h exp=0", bus.mem_req); else passed++;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL hit_no_mem_req_after got=%h exp=0", bus.mem_req); else passed++;
    checks++; if (hit_count !== 4'd1) $display("FAIL hit_count1 got=%0d exp=1", hit_count); else passed++;
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 32'h0000_0104, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0104;
    #1;
    checks++; if (bus.resp_valid !== 1'b1) $display("FAIL b2b_first_resp got=%h exp=1", bus.resp_valid); else passed++;
    checks++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_ready_in_resp got=%h exp=0", bus.req_ready); else passed++;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_after got=%h exp=1", bus.req_ready); else passed++;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL b2b_no_resp_idle got=%h exp=0", bus.resp_valid); else passed++;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b1) $display("FAIL b2b_second_resp got=%h exp=1", bus.resp_valid); else passed++;
    @(negedge clk);
    checks++; if (hit_count !== 4'd3) $display("FAIL b2b_hit_count got=%0d exp=3", hit_count); else passed++;
  endtask

  task automatic test_conflict;
    issue(1'b0, 32'h0000_0124, 32'h0);
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL conf_lookup_miss got=%h exp=0", bus.resp_valid); else passed++;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_rdata, bus.mem_addr} !== {1'b1, 32'hCAFE_F00D, 32'h0000_0124})
      $display("FAIL conf_fast_ack got v=%h d=%h a=%h exp v=1 d=cafef00d a=00000124", bus.resp_valid, bus.resp_rdata, bus.mem_addr);
    else passed++;
    checks++; if ({bus.cache_we, bus.cache_wtag} !== {1'b1, 27'h9}) $display("FAIL conf_fill_tag got we=%h tag=%h exp we=1 tag=9", bus.cache_we, bus.cache_wtag); else passed++;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    issue(1'b0, 32'h0000_0104, 32'h0);
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL conf_evicted_miss got=%h exp=0", bus.resp_valid); else passed++;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({bus.cache_we, bus.cache_wtag} !== {1'b1, 27'h8}) $display("FAIL conf_refill_tag got we=%h tag=%h exp we=1 tag=8", bus.cache_we, bus.cache_wtag); else passed++;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (miss_count !== 4'd3) $display("FAIL conf_miss_count got=%0d exp=3", miss_count); else passed++;
  endtask

  task automatic test_store;
    issue(1'b1, 32'h0000_0104, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if ({bus.cache_we, bus.cache_wtag, bus.cache_wdata} !== {1'b1, 27'h8, 32'h1234_5678})
      $display("FAIL st_hit_update got we=%h tag=%h data=%h exp we=1 tag=8 data=12345678", bus.cache_we, bus.cache_wtag, bus.cache_wdata);
    else passed++;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL st_lookup_resp got=%h exp=0", bus.resp_valid); else passed++;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678})
      $display("FAIL st_mem_wr got req=%h we=%h a=%h d=%h exp req=1 we=1 a=00000104 d=12345678", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else passed++;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_rdata, bus.cache_we} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL st_resp got v=%h d=%h cwe=%h exp v=1 d=0 cwe=0", bus.resp_valid, bus.resp_rdata, bus.cache_we);
    else passed++;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    checks++; if (hit_count !== 4'd4) $display("FAIL st_hit_count got=%0d exp=4", hit_count); else passed++;
    // Store miss: no array write, still written through.
    issue(1'b1, 32'h0000_0200, 32'hA5A5_A5A5);
    @(negedge clk);
    checks++; if (bus.cache_we !== 1'b0) $display("FAIL st_miss_no_cwe got=%h exp=0", bus.cache_we); else passed++;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if ({bus.resp_valid, bus.mem_we, bus.mem_wdata} !== {1'b1, 1'b1, 32'hA5A5_A5A5})
      $display("FAIL st_miss_resp got v=%h we=%h d=%h exp v=1 we=1 d=a5a5a5a5", bus.resp_valid, bus.mem_we, bus.mem_wdata);
    else passed++;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    checks++; if (miss_count !== 4'd4) $display("FAIL st_miss_count got=%0d exp=4", miss_count); else passed++;
    // Updated line now returns the stored word on a load hit.
    issue(1'b0, 32'h0000_0104, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.resp_valid, bus.resp_rdata} !== {1'b1, 32'h1234_5678})
      $display("FAIL st_readback got v=%h d=%h exp v=1 d=12345678", bus.resp_valid, bus.resp_rdata);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 32'h0000_0300, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) $display("FAIL rst_mid_pre_req got=%h exp=1", bus.mem_req); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mid_req_drop got=%h exp=0", bus.mem_req); else passed++;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_mid_ready got=%h exp=1", bus.req_ready); else passed++;
    checks++; if ({hit_count, miss_count} !== 8'h00) $display("FAIL rst_mid_counts got=%h exp=00", {hit_count, miss_count}); else passed++;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    #1;
    checks++;
    if ({bus.resp_valid, bus.cache_we} !== 2'b00)
      $display("FAIL rst_mid_late_ack got v=%h cwe=%h exp v=0 cwe=0", bus.resp_valid, bus.cache_we);
    else passed++;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.req_ready, miss_count} !== {1'b0, 1'b1, 4'd0})
      $display("FAIL rst_mid_after got req=%h rdy=%h miss=%0d exp req=0 rdy=1 miss=0", bus.mem_req, bus.req_ready, miss_count);
    else passed++;
  endtask

  task automatic test_saturation;
    for (int i = 1; i <= 17; i++) begin
      issue(1'b0, 32'(i) << 5, 32'h0);
      @(posedge clk);
      #1;
      if (i == 14) begin
        checks++; if (miss_count !== 4'd14) $display("FAIL sat_count14 got=%0d exp=14", miss_count); else passed++;
      end
      @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'(i);
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
    end
    @(negedge clk);
    checks++; if (miss_count !== 4'd15) $display("FAIL sat_miss_count got=%0d exp=15", miss_count); else passed++;
    checks++; if (hit_count !== 4'd0) $display("FAIL sat_hit_count got=%0d exp=0", hit_count); else passed++;
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    passed        = 0;
    rst_n         = 1'b0;
    arr_flush     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_back_to_back();
    test_conflict();
    test_store();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
